// File: rtl/sd_data_xfer_ctrl.sv
// sd_data_xfer_ctrl
//   Multi-block transfer sequencer between the register/DMA layer and the
//   SD data serial host. One accepted command (direction + block count) is
//   expanded into one host start handshake per block. CRC results are collected
//   per block, each block has a watchdog, and abort requests are handled. The
//   transfer ends with a single done pulse and sticky error flags.
//
// Host handshake, one block:
//   host_start is held at 01 (write) or 10 (read) until host_finish is seen
//   high. host_start then returns to 00. The next block is not issued until
//   host_finish has been seen low again. Code 11 asks the host to abort and is
//   driven for exactly two cycles.
//
// Ports
//   sd_clk, rst      clock; asynchronous active-high reset
//   cmd_start        one-cycle command request, accepted only when idle
//   cmd_dir          0 = write, 1 = read (sampled with cmd_start)
//   cmd_blkcnt       number of blocks (sampled with cmd_start)
//   cmd_abort        one-cycle abort request
//   blk_tmo          per-block watchdog limit in cycles, 0 = disabled
//   host_start       start code to the host (00/01/10/11)
//   host_busy        host busy (checked by assertion only)
//   host_finish      host block finished
//   host_crc_ok      host CRC result, valid with host_finish on reads
//   xfer_busy        high from acceptance until the done pulse
//   xfer_done        one-cycle completion pulse
//   err_crc/tmo/abort sticky error flags of the current/last transfer
//   blk_done_o       blocks completed successfully
//   dbg_state        current FSM state, for debug and checkers
module sd_data_xfer_ctrl #(
    parameter int BLKCNT_W = 16,
    parameter int TMO_W    = 32
) (
    input  logic                sd_clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic                cmd_dir,
    input  logic [BLKCNT_W-1:0] cmd_blkcnt,
    input  logic                cmd_abort,
    input  logic [TMO_W-1:0]    blk_tmo,
    output logic [1:0]          host_start,
    input  logic                host_busy,
    input  logic                host_finish,
    input  logic                host_crc_ok,
    output logic                xfer_busy,
    output logic                xfer_done,
    output logic                err_crc,
    output logic                err_tmo,
    output logic                err_abort,
    output logic [BLKCNT_W-1:0] blk_done_o,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_BLK = 3'd2,
        S_RELEASE  = 3'd3,
        S_ABORT    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state, w_state;
    logic                r_dir, w_dir;
    logic [BLKCNT_W-1:0] r_blkcnt, w_blkcnt;
    logic [TMO_W-1:0]    r_tmo, w_tmo;
    logic [TMO_W-1:0]    r_wdog, w_wdog;
    logic                r_abort_cnt, w_abort_cnt;
    logic [1:0]          r_host_start, w_host_start;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_err_crc, w_err_crc;
    logic                r_err_tmo, w_err_tmo;
    logic                r_err_abort, w_err_abort;
    logic [BLKCNT_W-1:0] r_blk_done, w_blk_done;

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dir        <= 1'b0;
            r_blkcnt     <= '0;
            r_tmo        <= '0;
            r_wdog       <= '0;
            r_abort_cnt  <= 1'b0;
            r_host_start <= 2'b00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err_crc    <= 1'b0;
            r_err_tmo    <= 1'b0;
            r_err_abort  <= 1'b0;
            r_blk_done   <= '0;
        end else begin
            r_state      <= w_state;
            r_dir        <= w_dir;
            r_blkcnt     <= w_blkcnt;
            r_tmo        <= w_tmo;
            r_wdog       <= w_wdog;
            r_abort_cnt  <= w_abort_cnt;
            r_host_start <= w_host_start;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_err_crc    <= w_err_crc;
            r_err_tmo    <= w_err_tmo;
            r_err_abort  <= w_err_abort;
            r_blk_done   <= w_blk_done;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_dir        = r_dir;
        w_blkcnt     = r_blkcnt;
        w_tmo        = r_tmo;
        w_wdog       = r_wdog;
        w_abort_cnt  = r_abort_cnt;
        w_host_start = r_host_start;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_err_crc    = r_err_crc;
        w_err_tmo    = r_err_tmo;
        w_err_abort  = r_err_abort;
        w_blk_done   = r_blk_done;

        case (r_state)
            S_IDLE: begin
                w_host_start = 2'b00;
                if (cmd_start) begin
                    w_dir       = cmd_dir;
                    w_blkcnt    = cmd_blkcnt;
                    w_tmo       = blk_tmo;
                    w_err_crc   = 1'b0;
                    w_err_tmo   = 1'b0;
                    w_err_abort = 1'b0;
                    w_blk_done  = '0;
                    w_busy      = 1'b1;
                    w_state     = (cmd_blkcnt == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_abort) begin
                    w_err_abort  = 1'b1;
                    w_host_start = 2'b11;
                    w_abort_cnt  = 1'b0;
                    w_state      = S_ABORT;
                end else begin
                    w_host_start = r_dir ? 2'b10 : 2'b01;
                    w_wdog       = '0;
                    w_state      = S_WAIT_BLK;
                end
            end
            S_WAIT_BLK: begin
                // Priority: abort, then finish, then watchdog. A block that
                // finishes in the abort cycle is not counted.
                if (cmd_abort) begin
                    w_err_abort  = 1'b1;
                    w_host_start = 2'b11;
                    w_abort_cnt  = 1'b0;
                    w_state      = S_ABORT;
                end else if (host_finish) begin
                    if (r_dir && !host_crc_ok) begin
                        w_err_crc = 1'b1;
                    end else begin
                        w_blk_done = r_blk_done + BLKCNT_W'(1);
                    end
                    w_host_start = 2'b00;
                    w_state      = S_RELEASE;
                end else if ((r_tmo != '0) && (r_wdog == r_tmo)) begin
                    w_err_tmo    = 1'b1;
                    w_host_start = 2'b11;
                    w_abort_cnt  = 1'b0;
                    w_state      = S_ABORT;
                end else begin
                    w_wdog = r_wdog + TMO_W'(1);
                end
            end
            S_RELEASE: begin
                if (cmd_abort) begin
                    w_err_abort  = 1'b1;
                    w_host_start = 2'b11;
                    w_abort_cnt  = 1'b0;
                    w_state      = S_ABORT;
                end else if (!host_finish) begin
                    w_state = (r_err_crc || (r_blk_done == r_blkcnt)) ? S_DONE : S_ISSUE;
                end
            end
            S_ABORT: begin
                // host_start was set to 11 on entry; keep it one more cycle.
                if (!r_abort_cnt) begin
                    w_abort_cnt = 1'b1;
                end else begin
                    w_host_start = 2'b00;
                    w_state      = S_DONE;
                end
            end
            S_DONE: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_host_start = 2'b00;
                w_state      = S_IDLE;
            end
        endcase
    end

    assign host_start = r_host_start;
    assign xfer_busy  = r_busy;
    assign xfer_done  = r_done;
    assign err_crc    = r_err_crc;
    assign err_tmo    = r_err_tmo;
    assign err_abort  = r_err_abort;
    assign blk_done_o = r_blk_done;
    assign dbg_state  = r_state;

    // The host must report busy while a block is outstanding.
    a_host_busy: assert property (@(posedge sd_clk) disable iff (rst)
        ((r_state == S_WAIT_BLK) && !host_finish) |-> host_busy);

endmodule
